iob_pfsm_loader: RTL and testbench

IOb-native bus initiator that programs an `iob_pfsm` instance without CPU involvement. It consumes a stream of LUT data words and issues the CSR writes the PFSM expects: `MEM_WORD_SELECT`, then `MEMORY` entries, then an optional `SOFTRESET` pulse. It sits between a boot ROM/DMA stream and the PFSM's IOb-native slave port, in place of the CPU.

---
 rtl/iob_pfsm_loader_pkg.sv | 23 ++
 rtl/iob_pfsm_loader_cnt.sv | 40 ++++
 rtl/iob_pfsm_loader.sv | 132 +++++++++++++
 tb/tb_iob_pfsm_loader.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/iob_pfsm_loader_pkg.sv
// iob_pfsm_loader_pkg: shared constants, FSM states and helpers for the PFSM loader.
// Default CSR byte addresses match the iob_pfsm register map.
// IOB_PFSM_LOADER_SOFTRESET_EN adds the two SOFTRESET write states.
package iob_pfsm_loader_pkg;
    localparam int PFSM_MEMORY_ADDR          = 'h100;
    localparam int PFSM_MEM_WORD_SELECT_ADDR = 'h8;
    localparam int PFSM_SOFTRESET_ADDR       = 'h0;

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        DATA,
`ifdef IOB_PFSM_LOADER_SOFTRESET_EN
        SRST_SET,
        SRST_CLR,
`endif
        DONE
    } state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction
endpackage

// File: rtl/iob_pfsm_loader_cnt.sv
// iob_pfsm_loader_cnt: word/entry counter pair walking the LUT in word-major order.
// Ports: clk_i, cke_i, rst_n_i (sync, active-low); clr_i restarts at word 0 entry 0;
// inc_i advances one entry, rolling into the next word after the last entry;
// word_o, entry_o current position; last_entry_o, last_word_o position flags.
module iob_pfsm_loader_cnt
    import iob_pfsm_loader_pkg::*;
#(
    parameter int ENTRY_W = 3,
    parameter int WORD_W  = 1,
    parameter int N_WORDS = 1
) (
    input  logic               clk_i,
    input  logic               cke_i,
    input  logic               rst_n_i,
    input  logic               clr_i,
    input  logic               inc_i,
    output logic [WORD_W-1:0]  word_o,
    output logic [ENTRY_W-1:0] entry_o,
    output logic               last_entry_o,
    output logic               last_word_o
);
    assign last_entry_o = &entry_o;
    assign last_word_o  = word_o == WORD_W'(N_WORDS - 1);

    always_ff @(posedge clk_i)
        if (!rst_n_i) begin
            word_o  <= '0;
            entry_o <= '0;
        end else if (cke_i) begin
            if (clr_i) begin
                word_o  <= '0;
                entry_o <= '0;
            end else if (inc_i) begin
                entry_o <= entry_o + 1'b1;
                // the word only advances on entry wrap, and never past the last word
                if (last_entry_o && !last_word_o)
                    word_o <= word_o + 1'b1;
            end
        end
endmodule

// File: rtl/iob_pfsm_loader.sv
// iob_pfsm_loader: IOb-native initiator that streams LUT chunks into an iob_pfsm.
// Ports: clk_i, cke_i (clock enable), rst_n_i (sync, active-low);
// start_i/busy_o/done_o load control; data_i/data_valid_i/data_ready_o chunk stream;
// iob_valid_o/iob_addr_o/iob_wdata_o/iob_wstrb_o/iob_ready_i write port;
// iob_rvalid_i/iob_rdata_i unused (write-only initiator).
// Define IOB_PFSM_LOADER_SOFTRESET_EN to pulse SOFTRESET after the LUT is written.
module iob_pfsm_loader
    import iob_pfsm_loader_pkg::*;
#(
    parameter int DATA_W               = 32,
    parameter int ADDR_W               = 16,
    parameter int STATE_W              = 2,
    parameter int INPUT_W              = 1,
    parameter int OUTPUT_W             = 1,
    parameter int MEMORY_ADDR          = PFSM_MEMORY_ADDR,
    parameter int MEM_WORD_SELECT_ADDR = PFSM_MEM_WORD_SELECT_ADDR,
    parameter int SOFTRESET_ADDR       = PFSM_SOFTRESET_ADDR
) (
    input  logic                clk_i,
    input  logic                cke_i,
    input  logic                rst_n_i,
    input  logic                start_i,
    output logic                busy_o,
    output logic                done_o,
    input  logic [DATA_W-1:0]   data_i,
    input  logic                data_valid_i,
    output logic                data_ready_o,
    output logic                iob_valid_o,
    output logic [ADDR_W-1:0]   iob_addr_o,
    output logic [DATA_W-1:0]   iob_wdata_o,
    output logic [DATA_W/8-1:0] iob_wstrb_o,
    input  logic                iob_ready_i,
    input  logic                iob_rvalid_i,
    input  logic [DATA_W-1:0]   iob_rdata_i
);
    localparam int LUT_DATA_W = STATE_W + OUTPUT_W;
    localparam int N_WORDS    = ceil_div(LUT_DATA_W, DATA_W);
    localparam int ENTRY_W    = STATE_W + INPUT_W;
    localparam int WORD_W     = N_WORDS > 1 ? $clog2(N_WORDS) : 1;
    localparam int BYTE_SHIFT = $clog2(DATA_W / 8);

    state_t              state, state_n;
    logic                valid_n;
    logic [ADDR_W-1:0]   addr_n;
    logic [DATA_W-1:0]   wdata_n;
    logic [WORD_W-1:0]   word;
    logic [ENTRY_W-1:0]  entry;
    logic                last_entry, last_word, ack, take;
    logic                unused;

    assign unused       = ^{iob_rvalid_i, iob_rdata_i};
    assign ack          = iob_valid_o && iob_ready_i;
    assign data_ready_o = cke_i && state == DATA && !iob_valid_o;
    assign take         = data_ready_o && data_valid_i;
    assign busy_o       = state != IDLE;
    assign done_o       = state == DONE;
    assign iob_wstrb_o  = {(DATA_W/8){iob_valid_o}};

    iob_pfsm_loader_cnt #(
        .ENTRY_W(ENTRY_W),
        .WORD_W (WORD_W),
        .N_WORDS(N_WORDS)
    ) cnt (
        .clk_i       (clk_i),
        .cke_i       (cke_i),
        .rst_n_i     (rst_n_i),
        .clr_i       (state == IDLE && start_i),
        .inc_i       (state == DATA && ack),
        .word_o      (word),
        .entry_o     (entry),
        .last_entry_o(last_entry),
        .last_word_o (last_word)
    );

    // A request drops after its handshake and the bus fields go back to zero;
    // each CSR state raises its request only from an idle bus, which yields the
    // mandatory idle cycle between consecutive writes.
    always_comb begin
        state_n = state;
        valid_n = iob_valid_o && !iob_ready_i;
        addr_n  = valid_n ? iob_addr_o : '0;
        wdata_n = valid_n ? iob_wdata_o : '0;
        case (state)
            IDLE: if (start_i) begin
                state_n = SEL;
                valid_n = 1'b1;
                addr_n  = ADDR_W'(MEM_WORD_SELECT_ADDR);
                wdata_n = '0;
            end
            SEL: if (!iob_valid_o) begin
                valid_n = 1'b1;
                addr_n  = ADDR_W'(MEM_WORD_SELECT_ADDR);
                wdata_n = DATA_W'(word);
            end else if (iob_ready_i) state_n = DATA;
            DATA: if (take) begin
                valid_n = 1'b1;
                addr_n  = ADDR_W'(MEMORY_ADDR) + (ADDR_W'(entry) << BYTE_SHIFT);
                wdata_n = data_i;
            end else if (ack && last_entry)
`ifdef IOB_PFSM_LOADER_SOFTRESET_EN
                state_n = last_word ? SRST_SET : SEL;
            SRST_SET: if (!iob_valid_o) begin
                valid_n = 1'b1;
                addr_n  = ADDR_W'(SOFTRESET_ADDR);
                wdata_n = DATA_W'(1);
            end else if (iob_ready_i) state_n = SRST_CLR;
            SRST_CLR: if (!iob_valid_o) begin
                valid_n = 1'b1;
                addr_n  = ADDR_W'(SOFTRESET_ADDR);
                wdata_n = '0;
            end else if (iob_ready_i) state_n = DONE;
`else
                state_n = last_word ? DONE : SEL;
`endif
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i)
        if (!rst_n_i) begin
            state       <= IDLE;
            iob_valid_o <= 1'b0;
            iob_addr_o  <= '0;
            iob_wdata_o <= '0;
        end else if (cke_i) begin
            state       <= state_n;
            iob_valid_o <= valid_n;
            iob_addr_o  <= addr_n;
            iob_wdata_o <= wdata_n;
        end
endmodule

// File: tb/tb_iob_pfsm_loader.sv
// tb_iob_pfsm_loader: randomized self-checking bench for iob_pfsm_loader (two-word LUT).
module tb_iob_pfsm_loader;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 16;
    localparam int OUTPUT_W  = 40;
    localparam int N_WORDS   = 2;
    localparam int N_ENTRIES = 8;
    localparam int N_CHUNKS  = N_WORDS * N_ENTRIES;
`ifdef IOB_PFSM_LOADER_SOFTRESET_EN
    localparam bit SRST = 1'b1;
`else
    localparam bit SRST = 1'b0;
`endif

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic cke_i = 1'b1, rst_n_i = 1'b0, start_i = 1'b0;
    logic busy_o, done_o, data_ready_o, iob_valid_o;
    logic [DATA_W-1:0] data_i = '0, iob_wdata_o, iob_rdata_i = '0;
    logic data_valid_i = 1'b0, iob_ready_i = 1'b1, iob_rvalid_i = 1'b0;
    logic [ADDR_W-1:0] iob_addr_o;
    logic [DATA_W/8-1:0] iob_wstrb_o;

    int checks = 0, errors = 0, cyc = 0;
    int done_cnt = 0, started = 0, ptr = 0;
    int last_start_cyc = 0, last_done_cyc = 0;
    int vp = 100, rp = 100, ckep = 100, stall_left = 0, hold_left = 0;
    logic [DATA_W-1:0] chunks [N_CHUNKS];
    wr_t exp_q [$];
    bit rst_after = 1'b1, done_now = 1'b0, prev_hs = 1'b0, prev_take = 1'b0;

    always #5 clk = ~clk;

    iob_pfsm_loader #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .STATE_W (2),
        .INPUT_W (1),
        .OUTPUT_W(OUTPUT_W)
    ) dut (
        .clk_i       (clk),
        .cke_i       (cke_i),
        .rst_n_i     (rst_n_i),
        .start_i     (start_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .data_i      (data_i),
        .data_valid_i(data_valid_i),
        .data_ready_o(data_ready_o),
        .iob_valid_o (iob_valid_o),
        .iob_addr_o  (iob_addr_o),
        .iob_wdata_o (iob_wdata_o),
        .iob_wstrb_o (iob_wstrb_o),
        .iob_ready_i (iob_ready_i),
        .iob_rvalid_i(iob_rvalid_i),
        .iob_rdata_i (iob_rdata_i)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected write list for one load: per word a select write, then every entry.
    function automatic void build();
        exp_q.delete();
        for (int w = 0; w < N_WORDS; w++) begin
            exp_q.push_back('{a: 16'h8, d: w});
            for (int e = 0; e < N_ENTRIES; e++)
                exp_q.push_back('{a: 16'h100 + 16'(4 * e), d: chunks[w * N_ENTRIES + e]});
        end
        if (SRST) begin
            exp_q.push_back('{a: 16'h0, d: 1});
            exp_q.push_back('{a: 16'h0, d: 0});
        end
    endfunction

    always @(negedge clk) begin
        bit idle_now, hs, take;
        cyc++;
        idle_now = exp_q.size() == 0 && !done_now;
        if (rst_after) begin
            chk("rst_outputs", {busy_o, done_o, data_ready_o, iob_valid_o, iob_addr_o, iob_wdata_o, iob_wstrb_o}, 0);
        end else begin
            chk("busy", busy_o, !idle_now);
            chk("done", done_o, done_now);
            chk("wstrb", iob_wstrb_o, iob_valid_o ? 4'hf : 4'h0);
            chk("data_ready", data_ready_o, cke_i && !iob_valid_o && exp_q.size() != 0 && exp_q[0].a >= 16'h100);
            if (prev_take) chk("chunk_to_req", iob_valid_o, 1);
            if (iob_valid_o) begin
                chk("idle_gap", prev_hs, 0);
                chk("req_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    chk("addr", iob_addr_o, exp_q[0].a);
                    chk("wdata", iob_wdata_o, exp_q[0].d);
                end
            end
        end
        hs = cke_i && iob_valid_o && iob_ready_i;
        take = cke_i && data_valid_i && data_ready_o;
        if (!rst_n_i) begin
            exp_q.delete();
            done_now = 0;
            prev_hs = 0;
            prev_take = 0;
            rst_after = 1;
        end else begin
            rst_after = 0;
            if (cke_i) begin
                prev_hs = hs;
                prev_take = take;
                if (done_now) begin
                    done_now = 0;
                    done_cnt++;
                end
                if (take) ptr++;
                if (hs && exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) begin
                        done_now = 1;
                        last_done_cyc = cyc + 1;
                    end
                end
                if (start_i && idle_now) begin
                    build();
                    ptr = 0;
                    started++;
                    last_start_cyc = cyc;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cke_i = $urandom_range(99) < ckep;
        data_i = chunks[ptr % N_CHUNKS];
        data_valid_i = $urandom_range(99) < vp;
        if (stall_left > 0 && ptr >= 3) begin
            data_valid_i = 1'b0;
            stall_left--;
        end
        iob_ready_i = $urandom_range(99) < rp;
        if (hold_left > 0 && iob_valid_o && iob_addr_o == 16'h108) begin
            iob_ready_i = 1'b0;
            hold_left--;
        end
        iob_rdata_i = $urandom;
        iob_rvalid_i = $urandom_range(1);
    endtask

    task automatic run_load(input int pulse_at);
        int n0, s0;
        foreach (chunks[i]) chunks[i] = $urandom;
        n0 = done_cnt;
        s0 = started;
        start_i = 1'b1;
        for (int i = 0; i < 50 && started == s0; i++) tick();
        start_i = 1'b0;
        chk("start_accepted", started - s0, 1);
        @(negedge clk);
        chk("first_req", {iob_valid_o, iob_addr_o, iob_wdata_o}, {1'b1, 16'h8, 32'h0});
        for (int i = 0; i < 2000 && done_cnt == n0; i++) begin
            tick();
            start_i = (i == pulse_at);
        end
        start_i = 1'b0;
        repeat (3) tick();
        chk("one_done_per_load", done_cnt - n0, 1);
    endtask

    initial begin
        foreach (chunks[i]) chunks[i] = '0;
        repeat (3) tick();
        rst_n_i = 1'b1;
        @(negedge clk);
        chk("reset_state", {busy_o, done_o, data_ready_o, iob_valid_o, iob_wstrb_o}, 0);

        // full rate: total load length is fixed
        run_load(-1);
        chk("load_cycles", last_done_cyc - last_start_cyc + 1, SRST ? 41 : 37);

        // back-pressure on the third memory write
        hold_left = 5;
        run_load(-1);
        chk("hold_applied", hold_left, 0);

        // stream stall plus a start pulse while busy
        stall_left = 10;
        run_load(12);
        chk("stall_applied", stall_left, 0);

        // reset during entry 4, then a clean reload
        foreach (chunks[i]) chunks[i] = $urandom;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 100 && ptr < 4; i++) tick();
        chk("reached_entry4", ptr, 4);
        rst_n_i = 1'b0;
        tick();
        rst_n_i = 1'b1;
        @(negedge clk);
        chk("rst_midload", {busy_o, done_o, data_ready_o, iob_valid_o, iob_addr_o, iob_wdata_o, iob_wstrb_o}, 0);
        run_load(-1);

        // randomized flow control and clock enable
        for (int k = 0; k < 6; k++) begin
            vp = $urandom_range(40, 100);
            rp = $urandom_range(30, 100);
            ckep = $urandom_range(70, 100);
            run_load($urandom_range(5, 30));
        end
        ckep = 100;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
